pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised next-generation program counter for the single-cycle core.
//  Generalises address width, word/byte addressing and field widths.
//  Adds pipeline stall, register-indirect jump, and call/return support via an
//  internal return-address stack (RAS).
//  Sits between the decoder/branch comparator and instruction memory; pc drives the fetch address.
// PARAMETERS
//  ADDR_W     32  width of pc and all address paths
//  INC_LOG2   0   log2 of bytes per instruction (0 = word-addressed, +1; 2 = byte-addressed, +4)
//  JUMP_W     26  width of absolute jump field
//  OFF_W      16  width of signed branch offset field
//  RAS_DEPTH  4   return-address stack entries (power of 2, >=2)
//  RESET_PC   0   pc value after reset
// PORTS
//  clk            in   1         rising-edge clock
//  reset          in   1         synchronous, active-high
//  stall          in   1         hold pc and RAS this cycle
//  branch         in   1         conditional branch instruction
//  zero           in   1         ALU zero flag; branch taken = branch & zero
//  jump           in   1         absolute jump
//  jump_reg       in   1         jump to reg_address
//  call           in   1         with jump/jump_reg: push return address
//  ret            in   1         return: pop RAS into pc
//  jump_address   in   JUMP_W    absolute jump field
//  branch_offset  in   OFF_W     signed offset, in instructions
//  reg_address    in   ADDR_W    register target; also ret fallback
//  pc             out  ADDR_W    current fetch address
//  ras_empty      out  1         RAS holds no entries
//  ras_full       out  1         RAS holds RAS_DEPTH entries
//  ras_error      out  1         sticky: overflow or underflow since reset
// BEHAVIOUR
//  - Reset: synchronous, active-high, wins over everything.
//    Sets pc=RESET_PC, RAS count=0, ras_empty=1, ras_full=0, ras_error=0.
//  - pc_plus = pc + (1<<INC_LOG2), modulo 2^ADDR_W (wraps silently).
//  - Next pc is taken at the clk edge. Priority, highest first:
//    reset > stall > ret > jump_reg > jump > branch taken > pc_plus.
//  - Targets:
//    ret      -> top of RAS
//    jump_reg -> reg_address
//    jump     -> {pc_plus[ADDR_W-1:JUMP_W+INC_LOG2], jump_address, INC_LOG2'b0}
//    branch   -> pc_plus + (sign_ext(branch_offset) << INC_LOG2)
//  - stall=1: pc, RAS contents, count and flags all hold. Every other input is ignored.
//  - call: push pc_plus only when the selected source is jump_reg or jump.
//    call with branch or sequential flow is ignored.
//    ret wins over call in the same cycle: pop happens, no push.
//  - RAS: circular buffer with top pointer and count 0..RAS_DEPTH.
//    Push when full: overwrite oldest entry, count stays RAS_DEPTH, ras_error<=1.
//  - ret when empty: pc<=reg_address, count stays 0, ras_error<=1.
//  - ras_empty and ras_full are registered and reflect count after the edge.
//  - Latency: every control decision is applied on the next rising edge.
//    pc is purely registered; no combinational path from inputs to pc.
//  - Defaults (RESET_PC=0, INC_LOG2=0, ADDR_W=32) reproduce the previous PC's
//    sequential, branch and jump behaviour exactly.
// TESTING
//  1 reset 2 cycles, then idle 3 cycles -> pc 0,1,2,3.
//    Assert reset at pc=3 -> pc=0 on the next edge, ras_empty=1.
//  2 pc=10, branch=1, zero=1, offset=16'hFFFC -> pc=7.
//    Same with zero=0 -> pc=11.
//  3 INC_LOG2=2, pc=32'h0000_0100, jump=1, jump_address=26'h40 -> pc=32'h0000_0100.
//    Sequential flow from there -> pc=32'h0000_0104.
//  4 pc=20, jump=1, call=1, jump_address=100 -> pc=100, ras_empty=0.
//    Then ret=1 -> pc=21.
//    Then ret=1 on the empty RAS with reg_address=55 -> pc=55, ras_error=1.
//  5 RAS_DEPTH=4: five calls from pcs 0,10,20,30,40 -> ras_full=1, ras_error=1.
//    Four rets -> pc 41,31,21,11, then ras_empty=1.
//  6 pc=8, stall=1 together with jump=1, ret=1, call=1 -> pc stays 8, RAS unchanged.
//    Release stall with ret=1 and jump=1 -> ret wins.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with stall, conditional branch,
// absolute and register-indirect jumps, and a circular return-address stack.
module pc_sequencer #(
  parameter int                 ADDR_W    = 32,
  parameter int                 INC_LOG2  = 0,
  parameter int                 JUMP_W    = 26,
  parameter int                 OFF_W     = 16,
  parameter int                 RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic              call,
  input  logic              ret,
  input  logic [JUMP_W-1:0] jump_address,
  input  logic [OFF_W-1:0]  branch_offset,
  input  logic [ADDR_W-1:0] reg_address,
  output logic [ADDR_W-1:0] pc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_error
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(RAS_DEPTH);
  // Bits of the jump target supplied by jump_address plus the alignment zeros.
  localparam logic [ADDR_W-1:0] LOW_MASK = (ADDR_W'(1) << (JUMP_W + INC_LOG2)) - ADDR_W'(1);

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BRANCH,
    SRC_JUMP,
    SRC_JREG,
    SRC_RET
  } src_t;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top, top_next;
  logic [CNT_W-1:0]  count, count_next;
  logic              error_next;
  logic [ADDR_W-1:0] pc_plus, pc_next, jump_target, branch_target, branch_disp;
  logic              push, pop;
  src_t              src;

  // Select the next-pc source by priority and derive the RAS update.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    pc_plus       = pc + (ADDR_W'(1) << INC_LOG2);
    jump_target   = (pc_plus & ~LOW_MASK) | (ADDR_W'(jump_address) << INC_LOG2);
    branch_disp   = {{(ADDR_W-OFF_W){branch_offset[OFF_W-1]}}, branch_offset};
    branch_target = pc_plus + (branch_disp << INC_LOG2);

    src = SRC_SEQ;
    if (ret)                  src = SRC_RET;
    else if (jump_reg)        src = SRC_JREG;
    else if (jump)            src = SRC_JUMP;
    else if (branch && zero)  src = SRC_BRANCH;

    push = call && (src == SRC_JREG || src == SRC_JUMP);
    pop  = (src == SRC_RET);

    case (src)
      SRC_RET:    pc_next = (count == '0) ? reg_address : ras_mem[top];
      SRC_JREG:   pc_next = reg_address;
      SRC_JUMP:   pc_next = jump_target;
      SRC_BRANCH: pc_next = branch_target;
      default:    pc_next = pc_plus;
    endcase

    top_next   = top;
    count_next = count;
    error_next = ras_error;
    if (push) begin
      // When full the slot above top is the oldest entry, so it is overwritten.
      top_next = top + PTR_W'(1);
      if (count == CNT_MAX) error_next = 1'b1;
      else                  count_next = count + CNT_W'(1);
    end else if (pop) begin
      if (count == '0) begin
        error_next = 1'b1;
      end else begin
        top_next   = top - PTR_W'(1);
        count_next = count - CNT_W'(1);
      end
    end
  end

  // Register pc, stack pointer/count and flags; stall freezes all of them.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      top       <= '0;
      count     <= '0;
      ras_empty <= 1'b1;
      ras_full  <= 1'b0;
      ras_error <= 1'b0;
    end else if (!stall) begin
      pc        <= pc_next;
      top       <= top_next;
      count     <= count_next;
      ras_empty <= (count_next == '0);
      ras_full  <= (count_next == CNT_MAX);
      ras_error <= error_next;
    end
  end

  // Write the return address into the stack storage.
  // NOTE: stack storage is not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && !stall && push) ras_mem[top_next] <= pc_plus;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, branch, zero, jump, jump_reg, call, ret;
  logic [25:0] jump_address;
  logic [15:0] branch_offset;
  logic [31:0] reg_address;
  logic [31:0] pc_w, pc_b;
  logic        empty_w, full_w, err_w, empty_b, full_b, err_b;

  int errors = 0;
  int checks = 0;

  // Reference model state for the word-addressed instance.
  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  bit          m_err;

  always #5 clk = ~clk;

  pc_sequencer #(.INC_LOG2(0)) dut_w (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .zero(zero),
    .jump(jump), .jump_reg(jump_reg), .call(call), .ret(ret),
    .jump_address(jump_address), .branch_offset(branch_offset),
    .reg_address(reg_address), .pc(pc_w), .ras_empty(empty_w),
    .ras_full(full_w), .ras_error(err_w)
  );

  pc_sequencer #(.INC_LOG2(2)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .zero(zero),
    .jump(jump), .jump_reg(jump_reg), .call(call), .ret(ret),
    .jump_address(jump_address), .branch_offset(branch_offset),
    .reg_address(reg_address), .pc(pc_b), .ras_empty(empty_b),
    .ras_full(full_b), .ras_error(err_b)
  );

  // Stack-machine view of the sequencer: a queue with the newest entry at the back.
  task automatic model_step();
    logic [31:0] pp;
    if (reset) begin
      m_pc = 32'd0;
      m_stk.delete();
      m_err = 1'b0;
    end else if (!stall) begin
      pp = m_pc + 32'd1;
      if (ret) begin
        if (m_stk.size() == 0) begin
          m_pc  = reg_address;
          m_err = 1'b1;
        end else begin
          m_pc = m_stk.pop_back();
        end
      end else if (jump_reg || jump) begin
        if (call) begin
          if (m_stk.size() == 4) begin
            void'(m_stk.pop_front());
            m_err = 1'b1;
          end
          m_stk.push_back(pp);
        end
        m_pc = jump_reg ? reg_address : {pp[31:26], jump_address};
      end else if (branch && zero) begin
        m_pc = pp + {{16{branch_offset[15]}}, branch_offset};
      end else begin
        m_pc = pp;
      end
    end
  endtask

  task automatic clear_inputs();
    reset = 0; stall = 0; branch = 0; zero = 0; jump = 0; jump_reg = 0;
    call = 0; ret = 0; jump_address = '0; branch_offset = '0; reg_address = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    clear_inputs(); reset = 1; tick();
  endtask

  task automatic goto_pc(input logic [31:0] a, input logic with_call);
    jump_reg = 1; call = with_call; reg_address = a; tick();
  endtask

  task automatic test_reset();
    do_reset(); reset = 1; tick();
    checks++; if (pc_w !== 32'd0 || empty_w !== 1'b1 || full_w !== 1'b0 || err_w !== 1'b0) begin
      errors++; $display("FAIL reset_state: pc=%0d e=%b f=%b err=%b want 0 1 0 0", pc_w, empty_w, full_w, err_w);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (pc_w !== 32'(i)) begin
        errors++; $display("FAIL seq_%0d: pc=%0d want %0d", i, pc_w, i);
      end
    end
    reset = 1; tick();
    checks++; if (pc_w !== 32'd0 || empty_w !== 1'b1) begin
      errors++; $display("FAIL reset_mid: pc=%0d e=%b want 0 1", pc_w, empty_w);
    end
  endtask

  task automatic test_branch();
    goto_pc(32'd10, 0);
    branch = 1; zero = 1; branch_offset = 16'hFFFC; tick();
    checks++; if (pc_w !== 32'd7) begin
      errors++; $display("FAIL branch_taken: pc=%0d want 7", pc_w);
    end
    goto_pc(32'd10, 0);
    branch = 1; zero = 0; branch_offset = 16'hFFFC; tick();
    checks++; if (pc_w !== 32'd11) begin
      errors++; $display("FAIL branch_not_taken: pc=%0d want 11", pc_w);
    end
  endtask

  task automatic test_byte_jump();
    do_reset();
    goto_pc(32'h0000_0100, 0);
    jump = 1; jump_address = 26'h40; tick();
    checks++; if (pc_b !== 32'h0000_0100) begin
      errors++; $display("FAIL byte_jump: pc=%h want 00000100", pc_b);
    end
    tick();
    checks++; if (pc_b !== 32'h0000_0104) begin
      errors++; $display("FAIL byte_seq: pc=%h want 00000104", pc_b);
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    goto_pc(32'd20, 0);
    jump = 1; call = 1; jump_address = 26'd100; tick();
    checks++; if (pc_w !== 32'd100 || empty_w !== 1'b0) begin
      errors++; $display("FAIL call: pc=%0d e=%b want 100 0", pc_w, empty_w);
    end
    ret = 1; tick();
    checks++; if (pc_w !== 32'd21 || empty_w !== 1'b1 || err_w !== 1'b0) begin
      errors++; $display("FAIL ret: pc=%0d e=%b err=%b want 21 1 0", pc_w, empty_w, err_w);
    end
    ret = 1; reg_address = 32'd55; tick();
    checks++; if (pc_w !== 32'd55 || err_w !== 1'b1 || empty_w !== 1'b1) begin
      errors++; $display("FAIL ret_underflow: pc=%0d err=%b e=%b want 55 1 1", pc_w, err_w, empty_w);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] want;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      goto_pc(32'(10 * i + 10), 1);
      checks++; if (full_w !== (i >= 3) || err_w !== (i == 4)) begin
        errors++; $display("FAIL push_%0d: full=%b err=%b want %b %b", i, full_w, err_w, i >= 3, i == 4);
      end
    end
    for (int i = 0; i < 4; i++) begin
      want = 32'(41 - 10 * i);
      ret = 1; tick();
      checks++; if (pc_w !== want) begin
        errors++; $display("FAIL pop_%0d: pc=%0d want %0d", i, pc_w, want);
      end
    end
    checks++; if (empty_w !== 1'b1 || full_w !== 1'b0) begin
      errors++; $display("FAIL drained: e=%b f=%b want 1 0", empty_w, full_w);
    end
  endtask

  task automatic test_stall();
    do_reset();
    goto_pc(32'd8, 1);
    stall = 1; jump = 1; ret = 1; call = 1; jump_address = 26'd300; tick();
    checks++; if (pc_w !== 32'd8 || empty_w !== 1'b0 || err_w !== 1'b0) begin
      errors++; $display("FAIL stall_hold: pc=%0d e=%b err=%b want 8 0 0", pc_w, empty_w, err_w);
    end
    ret = 1; jump = 1; jump_address = 26'd300; tick();
    checks++; if (pc_w !== 32'd1 || empty_w !== 1'b1) begin
      errors++; $display("FAIL ret_priority: pc=%0d e=%b want 1 1", pc_w, empty_w);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset         = ($urandom_range(0, 49) == 0);
      stall         = ($urandom_range(0, 7) == 0);
      ret           = ($urandom_range(0, 5) == 0);
      jump_reg      = ($urandom_range(0, 5) == 0);
      jump          = ($urandom_range(0, 5) == 0);
      call          = ($urandom_range(0, 2) == 0);
      branch        = ($urandom_range(0, 2) == 0);
      zero          = $urandom_range(0, 1);
      jump_address  = 26'($urandom);
      branch_offset = 16'($urandom);
      reg_address   = $urandom;
      tick();
      checks++; if (pc_w !== m_pc || empty_w !== (m_stk.size() == 0) ||
                    full_w !== (m_stk.size() == 4) || err_w !== m_err) begin
        errors++; $display("FAIL rand_%0d: pc=%h e=%b f=%b err=%b want %h %b %b %b", n, pc_w,
                           empty_w, full_w, err_w, m_pc, m_stk.size() == 0, m_stk.size() == 4, m_err);
      end
    end
  endtask

  initial begin
    clear_inputs();
    m_pc = '0; m_err = 0;
    test_reset();
    test_branch();
    test_byte_jump();
    test_call_ret();
    test_overflow();
    test_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
